// File: rtl/dadda_pkg.sv
// Shared types and defaults for the Dadda 4x4 multiplier and its downstream accumulator.
package dadda_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int PROD_W_DEF = 8;
    localparam int PROD_MAX   = 225;  // 15 x 15
    localparam int ACC_W_DEF  = 12;

endpackage

// File: rtl/sat_accum_add.sv
// Combinational saturating add of an unsigned product onto an unsigned accumulator.
module sat_accum_add #(
    parameter int ACC_W  = 12,
    parameter int PROD_W = 8
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W:0] wide;

    // Clamp to all ones whenever the extra top bit carries out.
    function automatic logic [ACC_W-1:0] sat(input logic [ACC_W:0] w);
        return w[ACC_W] ? {ACC_W{1'b1}} : w[ACC_W-1:0];
    endfunction

    assign wide = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    assign sum  = sat(wide);
    assign ovf  = wide[ACC_W];

endmodule

// File: rtl/dadda_mac_accum.sv
// Accumulates a framed stream of multiplier products into one saturated dot-product result
// and presents it on a valid/ready port.
module dadda_mac_accum
    import dadda_pkg::*;
#(
    parameter int PROD_W    = PROD_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAX_TERMS = 16,
    parameter int CNT_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc_p0;
    logic [CNT_W-1:0]   cnt_p0;
    logic               ovf_p0;
    logic               vld_p0;

    logic               accept;
    logic [ACC_W-1:0]   add_sum;
    logic               add_ovf;
    logic [CNT_W-1:0]   cnt_inc;
    logic               close_first;
    logic               close_accum;

    sat_accum_add #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_add (
        .acc  (acc_p0),
        .prod (in_prod),
        .sum  (add_sum),
        .ovf  (add_ovf)
    );

    assign in_ready    = (state != HOLD);
    assign accept      = in_valid & in_ready;
    assign cnt_inc     = cnt_p0 + 1'b1;
    assign close_first = in_last || (MAX_TERMS == 1);
    // A last flag coinciding with the count limit still yields a single close.
    assign close_accum = in_last || (cnt_inc == CNT_W'(MAX_TERMS));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = close_first ? HOLD : ACCUM;
            ACCUM:   if (accept) state_nxt = close_accum ? HOLD : ACCUM;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: accumulator, term count, sticky overflow and result-valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
            ovf_p0 <= 1'b0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= (state_nxt == HOLD);
            if (accept) begin
                if (state == IDLE) begin
                    acc_p0 <= ACC_W'(in_prod);
                    cnt_p0 <= CNT_W'(1);
                    ovf_p0 <= 1'b0;
                end else begin
                    acc_p0 <= add_sum;
                    cnt_p0 <= cnt_inc;
                    ovf_p0 <= ovf_p0 | add_ovf;
                end
            end
        end
    end

    assign out_valid = vld_p0;
    assign out_sum   = acc_p0;
    assign out_count = cnt_p0;
    assign out_ovf   = ovf_p0;

endmodule

// File: tb/tb_dadda_mac_accum.sv
// Self-checking bench for dadda_mac_accum: directed frames plus random traffic against a frame-level model.
module tb_dadda_mac_accum;

    localparam int MAX_TERMS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_prod;
    logic        in_last;
    logic        out_ready;

    logic        in_ready, out_valid, out_ovf;
    logic [11:0] out_sum;
    logic [4:0]  out_count;

    logic        in_ready11, out_valid11, out_ovf11;
    logic [10:0] out_sum11;
    logic [4:0]  out_count11;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level model state
    bit pend;
    bit zero_chk;
    int tot, cnt_m;
    int exp_cnt, exp_sum12, exp_sum11;
    bit exp_ovf12, exp_ovf11;

    always #5 clk = ~clk;

    dadda_mac_accum dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    dadda_mac_accum #(.ACC_W(11)) dut11 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready11),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid11),
        .out_ready (out_ready),
        .out_sum   (out_sum11),
        .out_count (out_count11),
        .out_ovf   (out_ovf11)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Predict the effect of the coming rising edge from the current inputs.
    task automatic model_edge();
        zero_chk = 1'b0;
        if (rst) begin
            pend = 1'b0; tot = 0; cnt_m = 0; zero_chk = 1'b1;
        end else if (pend) begin
            if (out_ready) pend = 1'b0;
        end else if (in_valid) begin
            tot   += int'(in_prod);
            cnt_m += 1;
            if (in_last || cnt_m == MAX_TERMS) begin
                pend      = 1'b1;
                exp_cnt   = cnt_m;
                exp_sum12 = (tot > 4095) ? 4095 : tot;
                exp_ovf12 = (tot > 4095);
                exp_sum11 = (tot > 2047) ? 2047 : tot;
                exp_ovf11 = (tot > 2047);
                tot = 0; cnt_m = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", in_ready, !pend);
        chk("out_valid", out_valid, pend);
        chk("in_ready11", in_ready11, !pend);
        chk("out_valid11", out_valid11, pend);
        if (pend) begin
            chk("out_sum", out_sum, exp_sum12);
            chk("out_count", out_count, exp_cnt);
            chk("out_ovf", out_ovf, exp_ovf12);
            chk("out_sum11", out_sum11, exp_sum11);
            chk("out_count11", out_count11, exp_cnt);
            chk("out_ovf11", out_ovf11, exp_ovf11);
        end
        if (zero_chk) begin
            chk("rst_sum", out_sum, 0);
            chk("rst_count", out_count, 0);
            chk("rst_ovf", out_ovf, 0);
            chk("rst_sum11", out_sum11, 0);
        end
    endtask

    task automatic step(input bit r, input bit v, input int p, input bit l, input bit ordy);
        rst = r; in_valid = v; in_prod = 8'(p); in_last = l; out_ready = ordy;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic beat(input int p, input bit l);
        step(1'b0, 1'b1, p, l, 1'b0);
    endtask

    task automatic handshake();
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        int vals[4];
        vals = '{6, 12, 20, 9};
        rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
        pend = 1'b0; zero_chk = 1'b0; tot = 0; cnt_m = 0;
        exp_cnt = 0; exp_sum12 = 0; exp_sum11 = 0; exp_ovf12 = 1'b0; exp_ovf11 = 1'b0;
        @(negedge clk);
        step(1'b1, 1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);   // out_ready with nothing pending

        // 6+12+20+9 closed by last
        for (int i = 0; i < 4; i++) beat(vals[i], i == 3);
        step(1'b0, 1'b0, 0, 1'b0, 1'b0);
        handshake();

        // One-term frame
        beat(225, 1'b1);
        handshake();
        step(1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Auto-close at MAX_TERMS; saturates only the narrow instance
        for (int i = 0; i < 16; i++) beat(225, 1'b0);
        // Back-pressure while result held
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 77, 1'b1, 1'b0);
        step(1'b0, 1'b1, 77, 1'b1, 1'b1);
        step(1'b0, 1'b1, 77, 1'b1, 1'b0);
        handshake();

        // Reset mid-frame, then 5 + 7
        for (int i = 0; i < 3; i++) beat(100, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        beat(5, 1'b0);
        beat(7, 1'b1);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);   // reset while holding a result

        // Last flag on the MAX_TERMS-th beat
        for (int i = 0; i < 16; i++) beat(i * 13, i == 15);
        handshake();
        step(1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 79) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 255),
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
